fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Pipelined-core instruction fetch stage plus IF/ID pipeline register.
- Owns the PC and issues one-outstanding-request fetches to instruction memory.
- Registers {pc, instruction} into IF/ID and drives if_id_opcode (instr[6:2]), the 5-bit field consumed by the decode-stage control unit.
- Handles hazard-unit stalls and EX-stage branch/jump redirects. Flushed slots present a canonical NOP.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when the IF/ID slot is invalid (addi x0,x0,0; opcode field 5'b00100).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard unit: hold IF/ID and PC.
- redirect_valid  in  1  branch taken or jump resolved.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (word aligned).
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of IF/ID instruction.
- if_id_instr  out  32  IF/ID instruction (NOP_INSTR when invalid).
- if_id_opcode  out  5  if_id_instr[6:2], to the control unit.

Behaviour:
- Reset (async, rst=0): pc=RESET_PC; state=IDLE; squash=0; buffer empty; if_id_valid=0; if_id_pc=0; if_id_instr=NOP_INSTR; imem_req=0; imem_addr=RESET_PC.
- Priority per cycle: reset > redirect > stall > normal.
- State machine:
  - IDLE: entered only from reset; goes to FETCH on the next clk.
  - FETCH: imem_req=1, imem_addr=pc. If imem_gnt=1, go to WAIT. imem_addr must stay stable while req=1 and gnt=0.
  - WAIT: imem_req=0. On imem_rvalid:
    - squash=1: discard data, clear squash, go to FETCH.
    - stall=0: load IF/ID with {valid=1, pc, rdata}; pc<=pc+4; go to FETCH.
    - stall=1: capture rdata in skid buffer; go to HOLD.
  - HOLD: imem_req=0. When stall=0: load IF/ID from buffer, pc<=pc+4, go to FETCH.
- Stall (no redirect): IF/ID registers and pc hold their values. A request already in FETCH may still be granted; memory is never back-pressured on rvalid.
- Redirect (any state):
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - if_id_valid<=0 and if_id_instr<=NOP_INSTR, even if stall=1.
  - FETCH with gnt=0: next cycle's address is the new pc; the request is not dropped.
  - FETCH with gnt=1, or WAIT without rvalid: set squash, enter WAIT, and discard the in-flight response.
  - WAIT with rvalid in the same cycle: drop the data, go to FETCH.
  - HOLD: discard the buffer, go to FETCH.
- Throughput: one instruction per 2 cycles minimum (FETCH+gnt, then WAIT+rvalid); latency grows with memory wait cycles.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- if_id_opcode is purely combinational from the if_id_instr register; when invalid it equals 5'b00100.
- imem_rvalid outside WAIT is ignored.
- Reset during WAIT: the subsequent stray rvalid arrives in IDLE/FETCH and is ignored.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, rdata = 32'h0000_0033 then 32'h0040_0093 -> imem_addr 0, then 4; IF/ID pc=0/instr=33/opcode=01100, then pc=4/opcode=00100; pc=8.
- stall=1 for 3 cycles while in WAIT with rvalid -> HOLD; IF/ID unchanged, imem_req=0; on release IF/ID gets the buffered word, pc+4.
- redirect_valid=1, redirect_pc=32'h0000_0102, in WAIT without rvalid -> next rvalid data dropped; if_id_valid=0, instr=13; next fetch address 32'h0000_0100.
- redirect in the same cycle as rvalid and stall=1 -> data dropped, if_id_valid=0, FETCH at target; redirect beats stall.
- gnt held 0 for 4 cycles in FETCH -> imem_req=1 and imem_addr stable; a redirect mid-wait changes the address the following cycle.
- pc=32'hFFFF_FFFC fetch completes -> pc wraps to 0. Assert rst=0 mid-WAIT -> all outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// One outstanding imem request; stalls hold IF/ID, redirects flush it.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic [4:0]  if_id_opcode
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic [31:0] buf_q, buf_d;
   logic        ifv_q, ifv_d;
   logic [31:0] ifpc_q, ifpc_d;
   logic [31:0] ifi_q, ifi_d;
   logic        load;
   logic [31:0] ld_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         squash_q <= 1'b0;
         buf_q    <= 32'h0;
         ifv_q    <= 1'b0;
         ifpc_q   <= 32'h0;
         ifi_q    <= NOP_INSTR;
      end else begin
         pc_q     <= pc_d;
         squash_q <= squash_d;
         buf_q    <= buf_d;
         ifv_q    <= ifv_d;
         ifpc_q   <= ifpc_d;
         ifi_q    <= ifi_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      buf_d    = buf_q;
      ifv_d    = ifv_q;
      ifpc_d   = ifpc_q;
      ifi_d    = ifi_q;
      load     = 1'b0;
      ld_data  = buf_q;
      if (redirect_valid) begin
         pc_d  = redirect_pc & ~32'h3;
         ifv_d = 1'b0;
         ifi_d = NOP_INSTR;
         unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (imem_gnt) begin
                  state_d  = S_WAIT;
                  squash_d = 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_d  = S_FETCH;
                  squash_d = 1'b0;
               end else begin
                  squash_d = 1'b1;
               end
            end
            S_HOLD: state_d = S_FETCH;
            default: state_d = S_IDLE;
         endcase
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (squash_q) begin
                     squash_d = 1'b0;
                     state_d  = S_FETCH;
                  end else if (!stall) begin
                     load    = 1'b1;
                     ld_data = imem_rdata;
                     state_d = S_FETCH;
                  end else begin
                     buf_d   = imem_rdata;
                     state_d = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  load    = 1'b1;
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
         // without a new word, an unstalled decode sees a bubble
         if (load) begin
            ifv_d  = 1'b1;
            ifpc_d = pc_q;
            ifi_d  = ld_data;
            pc_d   = pc_q + 32'd4;
         end else if (!stall) begin
            ifv_d = 1'b0;
            ifi_d = NOP_INSTR;
         end
      end
   end

   always_comb begin
      imem_req     = (state_q == S_FETCH);
      imem_addr    = pc_q;
      if_id_valid  = ifv_q;
      if_id_pc     = ifpc_q;
      if_id_instr  = ifi_q;
      if_id_opcode = ifi_q[6:2];
   end

endmodule
